// File: rtl/demux_1to8.sv
// Registered 1-to-8 demultiplexer: steers input bit i to output o[s] on each rising clk.
// Every output comes straight from a flop, so consumers never see decode glitches.
module demux_1to8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i,
    input  logic [2:0] s,
    output logic       o0,
    output logic       o1,
    output logic       o2,
    output logic       o3,
    output logic       o4,
    output logic       o5,
    output logic       o6,
    output logic       o7
);

    logic [7:0] next_out;
    logic [7:0] out_q;

    // Decode: at most one bit set, and only when i is high.
    always_comb begin
        next_out    = '0;
        next_out[s] = i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_q <= '0;
        else
            out_q <= next_out;
    end

    assign o0 = out_q[0];
    assign o1 = out_q[1];
    assign o2 = out_q[2];
    assign o3 = out_q[3];
    assign o4 = out_q[4];
    assign o5 = out_q[5];
    assign o6 = out_q[6];
    assign o7 = out_q[7];

endmodule

// File: tb/tb_demux_1to8.sv
// Scoreboard bench for demux_1to8: stimulus pushes expected outputs, a monitor pops
// and compares them one clock later; asynchronous reset behaviour is checked mid-cycle.
module tb_demux_1to8;

    logic       clk;
    logic       rst;
    logic       i;
    logic [2:0] s;
    logic       o0, o1, o2, o3, o4, o5, o6, o7;
    logic [7:0] dut_out;

    int checks;
    int errors;
    logic [7:0] exp_q[$];

    demux_1to8 dut (
        .clk(clk), .rst(rst), .i(i), .s(s),
        .o0(o0), .o1(o1), .o2(o2), .o3(o3),
        .o4(o4), .o5(o5), .o6(o6), .o7(o7)
    );

    assign dut_out = {o7, o6, o5, o4, o3, o2, o1, o0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the routed bit lands at weight 2**s, or nothing when i is 0 or reset wins.
    function automatic logic [7:0] model(input logic iv, input logic [2:0] sv, input bit in_reset);
        int value;
        if (in_reset || !iv)
            value = 0;
        else
            value = 2 ** int'(sv);
        return value[7:0];
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] expected);
        checks++;
        if (dut_out !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, required %b at %0t", name, dut_out, expected, $time);
        end
    endtask

    // Drive one routing decision at the falling edge; hold_rst keeps reset asserted over the next rising edge.
    task automatic applyStimulus(input logic iv, input logic [2:0] sv, input bit hold_rst);
        @(negedge clk);
        i   = iv;
        s   = sv;
        rst = hold_rst;
        exp_q.push_back(model(iv, sv, hold_rst));
    endtask

    initial begin
        logic [7:0] expected;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                expected = exp_q.pop_front();
                checkOutput("edge_load", expected);
                checks++;
                if ($countones(dut_out) > 1) begin
                    errors++;
                    $display("[TB] FAIL onehot: got %b, required at most one bit high", dut_out);
                end
            end
        end
    end

    initial begin
        int waited;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        i   = 1'b0;
        s   = 3'b000;
        #1;
        checkOutput("reset_state", 8'h00);
        repeat (2) @(posedge clk);

        $display("[TB] select sweep with i=1");
        for (int k = 0; k < 8; k++)
            applyStimulus(1'b1, 3'(k), 1'b0);

        $display("[TB] zero input sweep");
        for (int k = 0; k < 8; k++)
            applyStimulus(1'b0, 3'(k), 1'b0);

        $display("[TB] async reset mid-cycle, release before edge");
        applyStimulus(1'b1, 3'b011, 1'b0);
        applyStimulus(1'b1, 3'b101, 1'b0);
        #2 rst = 1'b1;
        #1 checkOutput("reset_immediate", 8'h00);
        rst = 1'b0;

        $display("[TB] reset held across an edge");
        applyStimulus(1'b1, 3'b111, 1'b1);
        applyStimulus(1'b1, 3'b111, 1'b0);

        $display("[TB] latency check");
        applyStimulus(1'b1, 3'b000, 1'b0);
        applyStimulus(1'b1, 3'b110, 1'b0);
        #3 checkOutput("latency_hold_o0", 8'h01);

        $display("[TB] mid-operation reset pulse");
        applyStimulus(1'b1, 3'b010, 1'b0);
        applyStimulus(1'b1, 3'b010, 1'b0);
        #1 checkOutput("midop_before", 8'h04);
        rst = 1'b1;
        #1 checkOutput("midop_drop", 8'h00);
        rst = 1'b0;
        #1 checkOutput("midop_stay_low", 8'h00);

        $display("[TB] toggle i on s=4");
        for (int k = 0; k < 8; k++)
            applyStimulus(1'(k % 2 == 0), 3'b100, 1'b0);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 300; k++)
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          $urandom_range(0, 15) == 0);
        applyStimulus(1'b0, 3'b000, 1'b0);

        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
